memory_interface_unit: RTL and testbench
========================================

Name: memory_interface_unit

Overview:
- Byte-addressable data/instruction memory that sits directly downstream of the control unit.
- Consumes the control unit's MOV, R/W and data-size signals, plus the MAR address and MDR write data.
- Produces the MOC (memory operation complete) handshake that the control unit tests in its wait states, and the read data loaded into MDR/IR.
- Access latency is programmable, so the control unit's MOC wait loops are exercised for real.

Parameters:
- ADDR_WIDTH, 8, byte-address width; memory depth = 2**ADDR_WIDTH bytes.
- LATENCY, 2, rising edges from MOV acceptance to MOC assertion; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- mov  input  1  memory operation valid, from control unit MOV
- rw  input  1  1 = read, 0 = write (control unit R/W)
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- addr  input  ADDR_WIDTH  byte address, from MAR
- data_in  input  32  write data, from MDR
- data_out  output  32  read data to MDR/IR
- moc  output  1  memory operation complete
- busy  output  1  high while an operation is outstanding (WAIT or DONE)

Behaviour:
- Reset is asynchronous and active-high. It forces state=IDLE, moc=0, busy=0, data_out=0 and counter=0. Memory array contents are NOT cleared.
- Storage is big-endian: word at A occupies bytes A (bits 31:24) through A+3 (bits 7:0).
- Alignment: for halfword, addr[0] is forced to 0; for word, addr[1:0] are forced to 00. No fault is raised.
- Reads zero-extend: byte -> data_out[7:0], halfword -> data_out[15:0], upper bits 0.
- Writes use data_in[7:0] (byte), data_in[15:0] (halfword) or all 32 bits (word).
- Addresses wrap modulo 2**ADDR_WIDTH for multi-byte accesses; none occur once alignment is applied.
- State machine:
  - IDLE: busy=0, moc=0. On a rising edge with mov=1, latch addr, rw, size and data_in into request registers and set counter=LATENCY-1. Go to DONE if LATENCY=1, else go to WAIT.
  - WAIT: busy=1, moc=0. Counter decrements each edge. On the edge where counter==1 (after the decrement it would reach 0), go to DONE. Input changes during WAIT are ignored; the latched request is used.
  - Entering DONE (same edge): for a read, data_out <= memory data at the latched address; for a write, the array is updated. Then moc=1, busy=1.
  - DONE: moc stays 1 and data_out holds while mov=1. On an edge with mov=0, go to IDLE; moc falls in that same cycle.
- Timing: if mov is sampled high at edge k, moc is high from edge k+LATENCY. data_out is valid at the same edge moc rises.
- data_out keeps its last read value through writes and IDLE. It changes only on read completion or reset.
- mov dropped during WAIT: the operation still completes, including commit of a pending write. DONE is entered, then exits to IDLE on the next edge because mov=0. moc pulses for exactly one cycle.
- A new mov=1 in DONE does not start a new operation. The control unit must drop mov for at least one cycle between operations, which its state sequencing guarantees.
- Reset asserted during WAIT aborts the operation: a pending write is NOT committed, and moc stays 0.
- Preload for simulation uses a $readmemb/$readmemh-style initial load. It is not part of the synthesizable behaviour.

Test Plan:
- Reset mid-idle, then word write 0xDEADBEEF to addr 0x04 with LATENCY=2 -> moc rises exactly 2 edges after mov is sampled; bytes 0x04..0x07 = DE,AD,BE,EF.
- Byte read of addr 0x05 after the above -> data_out = 0x000000AD. Halfword read at addr 0x07 (aligned to 0x06) -> data_out = 0x0000BEEF.
- Byte write 0x12345677 to addr 0x06, then word read 0x04 -> data_out = 0xDEAD77EF. Verify moc stays high while mov is held 5 extra cycles, and falls the cycle after mov drops.
- LATENCY=1 instance: word read of addr 0x00 (preloaded 0xE0846004) -> moc high on the first edge after acceptance; busy never shows a WAIT cycle.
- Reset asserted one cycle into a LATENCY=3 word write of 0xCAFEF00D to 0x10 -> moc=0, busy=0 and data_out=0 immediately. A later read of 0x10 returns the old contents, not 0xCAFEF00D.
- Change addr and data_in during WAIT, and drop mov mid-WAIT -> the original latched request is performed and moc pulses high for exactly one cycle.

Source files
------------

// File: rtl/memory_interface_unit.sv
// Byte-addressable big-endian memory with programmable access latency and a
// MOV/MOC handshake for the control unit's wait states.
module memory_interface_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mov,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [7:0] mem [0:DEPTH-1];

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  req_rw;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;

  logic                  accept_c;
  logic                  complete_c;
  logic                  cur_rw_c;
  logic [1:0]            cur_size_c;
  logic [ADDR_WIDTH-1:0] cur_addr_c;
  logic [31:0]           cur_data_c;
  logic [ADDR_WIDTH-1:0] a1_c;
  logic [ADDR_WIDTH-1:0] a2_c;
  logic [ADDR_WIDTH-1:0] a3_c;
  logic [31:0]           rd_data_c;

  // Force halfword/word addresses onto their natural boundary.
  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] sz);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    if (sz == SZ_HALF) r[0] = 1'b0;
    else if (sz != SZ_BYTE) r[1:0] = 2'b00;
    return r;
  endfunction

  // Active request: live inputs on the accepting edge (LATENCY=1), latched copy afterwards.
  always_comb begin
    cur_rw_c   = req_rw;
    cur_size_c = req_size;
    cur_addr_c = req_addr;
    cur_data_c = req_data;
    if (state == S_IDLE) begin
      cur_rw_c   = rw;
      cur_size_c = size;
      cur_addr_c = align_addr(addr, size);
      cur_data_c = data_in;
    end
    a1_c = cur_addr_c + ADDR_WIDTH'(1);
    a2_c = cur_addr_c + ADDR_WIDTH'(2);
    a3_c = cur_addr_c + ADDR_WIDTH'(3);
  end

  // Big-endian, zero-extended read data for the active request.
  always_comb begin
    rd_data_c = 32'd0;
    case (cur_size_c)
      SZ_BYTE: rd_data_c = {24'd0, mem[cur_addr_c]};
      SZ_HALF: rd_data_c = {16'd0, mem[cur_addr_c], mem[a1_c]};
      default: rd_data_c = {mem[cur_addr_c], mem[a1_c], mem[a2_c], mem[a3_c]};
    endcase
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (mov) begin
          accept_c = 1'b1;
          cnt_nxt  = CNT_W'(LATENCY - 1);
          if (LATENCY <= 1) begin
            state_nxt  = S_DONE;
            complete_c = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt  = S_DONE;
          complete_c = 1'b1;
        end
      end
      S_DONE: begin
        if (!mov) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counter and request latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      req_rw   <= 1'b0;
      req_size <= 2'b00;
      req_addr <= '0;
      req_data <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_c) begin
        req_rw   <= rw;
        req_size <= size;
        req_addr <= align_addr(addr, size);
        req_data <= data_in;
      end
    end
  end

  // Registered handshake outputs and read data (held except on read completion).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moc      <= 1'b0;
      busy     <= 1'b0;
      data_out <= 32'd0;
    end else begin
      moc  <= (state_nxt == S_DONE);
      busy <= (state_nxt != S_IDLE);
      if (complete_c && cur_rw_c) data_out <= rd_data_c;
    end
  end

  // Array commit on write completion; contents survive reset, and reset blocks a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset) begin
      if (complete_c && !cur_rw_c) begin
        case (cur_size_c)
          SZ_BYTE: mem[cur_addr_c] <= cur_data_c[7:0];
          SZ_HALF: begin
            mem[cur_addr_c] <= cur_data_c[15:8];
            mem[a1_c]       <= cur_data_c[7:0];
          end
          default: begin
            mem[cur_addr_c] <= cur_data_c[31:24];
            mem[a1_c]       <= cur_data_c[23:16];
            mem[a2_c]       <= cur_data_c[15:8];
            mem[a3_c]       <= cur_data_c[7:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_interface_unit.sv
// Bench for memory_interface_unit: three instances (LATENCY 1, 2, 3) sharing
// request inputs, with a byte-array model and a read-data scoreboard.
module tb_memory_interface_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mov_v [3];
  logic        rw_s;
  logic [1:0]  size_s;
  logic [7:0]  addr_s;
  logic [31:0] din_s;
  logic [31:0] dout_v [3];
  logic        moc_v [3];
  logic        busy_v [3];

  int checks = 0;
  int passes = 0;
  logic [7:0]  model_mem [3][256];
  logic [31:0] last_rd [3];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  memory_interface_unit #(.ADDR_WIDTH(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .mov(mov_v[0]), .rw(rw_s), .size(size_s), .addr(addr_s),
    .data_in(din_s), .data_out(dout_v[0]), .moc(moc_v[0]), .busy(busy_v[0]));
  memory_interface_unit #(.ADDR_WIDTH(8), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .mov(mov_v[1]), .rw(rw_s), .size(size_s), .addr(addr_s),
    .data_in(din_s), .data_out(dout_v[1]), .moc(moc_v[1]), .busy(busy_v[1]));
  memory_interface_unit #(.ADDR_WIDTH(8), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .mov(mov_v[2]), .rw(rw_s), .size(size_s), .addr(addr_s),
    .data_in(din_s), .data_out(dout_v[2]), .moc(moc_v[2]), .busy(busy_v[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] al(input logic [7:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return a;
    if (sz == 2'b01) return a & 8'hFE;
    return a & 8'hFC;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [7:0] a, input logic [1:0] sz);
    logic [7:0] b;
    b = al(a, sz);
    if (sz == 2'b00) return {24'h0, model_mem[i][b]};
    if (sz == 2'b01) return {16'h0, model_mem[i][b], model_mem[i][b + 8'd1]};
    return {model_mem[i][b], model_mem[i][b + 8'd1], model_mem[i][b + 8'd2], model_mem[i][b + 8'd3]};
  endfunction

  task automatic model_write(input int i, input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] b;
    b = al(a, sz);
    if (sz == 2'b00) model_mem[i][b] = d[7:0];
    else if (sz == 2'b01) begin
      model_mem[i][b] = d[15:8];
      model_mem[i][b + 8'd1] = d[7:0];
    end else begin
      model_mem[i][b] = d[31:24];
      model_mem[i][b + 8'd1] = d[23:16];
      model_mem[i][b + 8'd2] = d[15:8];
      model_mem[i][b + 8'd3] = d[7:0];
    end
  endtask

  // Full handshake: drive, wait (bounded) for moc, hold mov `hold` extra cycles, drop.
  task automatic run_op(input int i, input logic r, input logic [1:0] sz, input logic [7:0] a,
                        input logic [31:0] d, input int hold, input string tag);
    int edges = 0;
    bit wait_seen = 0;
    logic [31:0] exp;
    rw_s = r; size_s = sz; addr_s = a; din_s = d; mov_v[i] = 1'b1;
    if (r) exp_q.push_back(model_read(i, a, sz));
    else model_write(i, a, sz, d);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (busy_v[i] && !moc_v[i]) wait_seen = 1;
      if (moc_v[i]) begin edges = e; break; end
    end
    check({tag, "_lat"}, 64'(edges), 64'(i + 1));
    check({tag, "_waitcyc"}, 64'(wait_seen), 64'(i > 0));
    if (edges != 0) begin
      if (r) begin
        exp = exp_q.pop_front();
        last_rd[i] = exp;
      end
      check({tag, "_data"}, 64'(dout_v[i]), 64'(last_rd[i]));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {31'd0, moc_v[i], dout_v[i]}, {31'd0, 1'b1, last_rd[i]});
    end
    mov_v[i] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_release"}, {62'd0, moc_v[i], busy_v[i]}, 64'd0);
  endtask

  // Inputs scrambled and mov dropped right after acceptance; latched request must still run.
  task automatic run_interrupted(input int i, input logic r, input logic [1:0] sz, input logic [7:0] a,
                                 input logic [31:0] d, input string tag);
    int hi = 0;
    bit seen = 0;
    logic [31:0] exp;
    rw_s = r; size_s = sz; addr_s = a; din_s = d; mov_v[i] = 1'b1;
    if (r) exp_q.push_back(model_read(i, a, sz));
    else model_write(i, a, sz, d);
    @(posedge clk); #1;
    rw_s = ~r; size_s = 2'b00; addr_s = a ^ 8'h2C; din_s = ~d; mov_v[i] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (moc_v[i]) begin
        hi++;
        if (!seen) begin
          seen = 1;
          if (r) begin
            exp = exp_q.pop_front();
            last_rd[i] = exp;
          end
          check({tag, "_data"}, 64'(dout_v[i]), 64'(last_rd[i]));
        end
      end else if (seen) break;
    end
    check({tag, "_moc_pulse"}, 64'(hi), 64'd1);
    check({tag, "_idle"}, 64'(busy_v[i]), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mov_v[i] = 1'b0; last_rd[i] = 32'd0; end
    rw_s = 1'b1; size_s = 2'b10; addr_s = 8'h00; din_s = 32'd0;

    // Reset while idle.
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outs%0d", i), {30'd0, moc_v[i], busy_v[i], dout_v[i]}, 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // LATENCY=2: word write then big-endian byte/halfword reads.
    run_op(1, 1'b0, 2'b10, 8'h04, 32'hDEADBEEF, 0, "l2_wr_w04");
    for (int b = 4; b < 8; b++) run_op(1, 1'b1, 2'b00, 8'(b), 32'd0, 0, $sformatf("l2_rd_b%0d", b));
    check("l2_rd_b07_value", 64'(last_rd[1]), 64'h0000_00EF);
    run_op(1, 1'b1, 2'b00, 8'h05, 32'd0, 0, "l2_rd_b05");
    check("l2_rd_b05_value", 64'(last_rd[1]), 64'h0000_00AD);
    run_op(1, 1'b1, 2'b01, 8'h07, 32'd0, 0, "l2_rd_h07");
    check("l2_rd_h07_value", 64'(last_rd[1]), 64'h0000_BEEF);
    run_op(1, 1'b0, 2'b00, 8'h06, 32'h12345677, 0, "l2_wr_b06");
    run_op(1, 1'b1, 2'b10, 8'h04, 32'd0, 5, "l2_rd_w04_hold");
    check("l2_rd_w04_value", 64'(last_rd[1]), 64'hDEAD_77EF);
    run_op(1, 1'b1, 2'b11, 8'h05, 32'd0, 0, "l2_rd_rsvd05");

    // LATENCY=1: preload via write, then a no-wait word read.
    run_op(0, 1'b0, 2'b10, 8'h00, 32'hE0846004, 0, "l1_wr_w00");
    run_op(0, 1'b1, 2'b10, 8'h00, 32'd0, 0, "l1_rd_w00");
    check("l1_rd_w00_value", 64'(last_rd[0]), 64'hE084_6004);

    // Mid-WAIT input changes with mov dropped.
    run_interrupted(2, 1'b0, 2'b10, 8'h20, 32'hA5A55A5A, "l3_int_wr20");
    run_op(2, 1'b1, 2'b10, 8'h20, 32'd0, 0, "l3_rd_w20");
    check("l3_rd_w20_value", 64'(last_rd[2]), 64'hA5A5_5A5A);
    run_interrupted(1, 1'b1, 2'b10, 8'h04, 32'd0, "l2_int_rd04");

    // Reset one cycle into a LATENCY=3 write aborts the commit.
    run_op(2, 1'b0, 2'b10, 8'h10, 32'h11223344, 0, "l3_wr_w10");
    run_op(2, 1'b1, 2'b10, 8'h10, 32'd0, 0, "l3_rd_w10_pre");
    rw_s = 1'b0; size_s = 2'b10; addr_s = 8'h10; din_s = 32'hCAFEF00D; mov_v[2] = 1'b1;
    @(posedge clk); #1;
    check("l3_abort_busy_pre", 64'(busy_v[2]), 64'd1);
    mov_v[2] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("l3_abort_outs", {30'd0, moc_v[2], busy_v[2], dout_v[2]}, 64'd0);
    check("l2_reset_dout", 64'(dout_v[1]), 64'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("l3_after_reset_moc", 64'(moc_v[2]), 64'd0);
    run_op(2, 1'b1, 2'b10, 8'h10, 32'd0, 0, "l3_rd_w10_post");
    check("l3_rd_w10_old", 64'(last_rd[2]), 64'h1122_3344);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
